flags_branch_unit: RTL and testbench
====================================

Name: flags_branch_unit

Overview:
- Consumes the ALU's zero/carry outputs. Holds the architectural Z/C flag register and the program counter.
- Resolves conditional jumps against the flags and drives the PC for instruction fetch.
- Sits between the ALU result path and the fetch stage. After every taken branch it issues a one-cycle flush.

Parameters:
PC_WIDTH, 8, width of program counter and branch target
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
zero_in  input  1  zero flag from ALU
carry_in  input  1  carry flag from ALU
flag_we  input  1  latch zero_in/carry_in into flag register this cycle
step  input  1  advance one instruction this cycle
br_valid  input  1  current instruction is a branch (sampled only when step=1)
br_cond  input  3  0 NONE, 1 JMP, 2 JZ, 3 JNZ, 4 JC, 5 JNC, 6-7 reserved
br_target  input  PC_WIDTH  branch destination
halt  input  1  request halt / hold halted
pc  output  PC_WIDTH  current program counter (registered)
zero_flag  output  1  stored Z flag (registered)
carry_flag  output  1  stored C flag (registered)
br_taken  output  1  registered one-cycle pulse: branch taken on previous edge
flush  output  1  high while in FLUSH state (decoded from state register)
cond_err  output  1  registered one-cycle pulse: reserved br_cond evaluated
halted  output  1  high while in HALTED state

Behaviour:
- Reset (async, immediate on rst=1):
  - pc=RESET_PC; zero_flag=0; carry_flag=0.
  - br_taken=0; cond_err=0; state=RUN, so flush=0 and halted=0.
- FSM states: RUN, FLUSH, HALTED.
- RUN:
  - halt=1: go to HALTED. step, br_valid and flag_we are ignored that cycle; halt has priority.
  - Otherwise, flag_we=1: zero_flag<=zero_in, carry_flag<=carry_in.
  - step=1 and br_valid=1: evaluate condition (below).
    - Taken: pc<=br_target, br_taken<=1, go to FLUSH.
    - Not taken: pc<=pc+1.
  - step=1 and br_valid=0: pc<=pc+1.
  - step=0: pc holds; br_valid is ignored.
- Condition evaluation uses the effective flags Zf/Cf:
  - If flag_we=1 in the same cycle, Zf/Cf are the incoming zero_in/carry_in (forwarded).
  - Otherwise Zf/Cf are the stored zero_flag/carry_flag.
  - Taken when: NONE never; JMP always; JZ Zf=1; JNZ Zf=0; JC Cf=1; JNC Cf=0.
  - Reserved codes 6-7: not taken, pc<=pc+1, cond_err pulses for 1 cycle.
- FLUSH (exactly one cycle):
  - flush=1; pc holds.
  - step, br_valid and flag_we are ignored, because the instruction is squashed.
  - Next state is HALTED if halt=1, else RUN.
- HALTED:
  - pc and flags hold; halted=1; all other inputs ignored.
  - Returns to RUN on the first cycle with halt=0. The first step is accepted on the following cycle.
- br_taken and cond_err are 0 in every cycle not specified above.
- pc+1 wraps modulo 2^PC_WIDTH: 255 -> 0 for the default width. No error is raised.
- A taken branch to the current pc is legal. It still flushes.
- rst asserted mid-operation (any state, including FLUSH) restores all reset values immediately. First advance is on the first step after rst deasserts.

Test Plan:
- Reset, then step=1 for 3 cycles -> pc 0,1,2,3; flags 0; flush never asserted.
- zero_in=1, flag_we=1, step=1, br_valid=1, br_cond=2 (JZ), br_target=8'h40 (same cycle) -> forwarded Z taken: next pc=8'h40, br_taken=1 for one cycle, flush=1 the following cycle, pc holds during flush, then pc increments 8'h41.
- Stored zero_flag=0, carry_flag=1; JNZ target 8'h10 -> taken; then JNC target 8'h20 -> not taken (pc+1); then br_cond=6 -> not taken, cond_err=1 for one cycle.
- pc=8'hFF, step=1, no branch -> pc=8'h00, no error.
- halt=1 with step=1 and br_valid=1 JMP in RUN -> halted=1, pc unchanged; hold halt 4 cycles with step=1 -> pc unchanged; drop halt -> RUN next cycle, step resumes increment.
- Taken JMP, assert rst during the FLUSH cycle -> pc=RESET_PC, flush=0, br_taken=0, flags=0 immediately (before next edge).

Source files
------------

// File: rtl/flags_branch_if.sv
// Bundles the ALU-flag, step/branch request and PC/status signals exchanged
// between the sequencer side and flags_branch_unit.
interface flags_branch_if #(
  parameter int PC_WIDTH = 8
);
  logic                zero_in;
  logic                carry_in;
  logic                flag_we;
  logic                step;
  logic                br_valid;
  logic [2:0]          br_cond;
  logic [PC_WIDTH-1:0] br_target;
  logic                halt;
  logic [PC_WIDTH-1:0] pc;
  logic                zero_flag;
  logic                carry_flag;
  logic                br_taken;
  logic                flush;
  logic                cond_err;
  logic                halted;

  modport master (
    output zero_in, carry_in, flag_we, step, br_valid, br_cond, br_target, halt,
    input  pc, zero_flag, carry_flag, br_taken, flush, cond_err, halted
  );

  modport slave (
    input  zero_in, carry_in, flag_we, step, br_valid, br_cond, br_target, halt,
    output pc, zero_flag, carry_flag, br_taken, flush, cond_err, halted
  );
endinterface

// File: rtl/flags_branch_unit.sv
// Z/C flag register, program counter and branch resolver with a RUN/FLUSH/HALTED
// sequencer; a taken branch squashes the following instruction via flush.
module flags_branch_unit #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst,
  flags_branch_if.slave  bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_JMP  = 3'd1;
  localparam logic [2:0] C_JZ   = 3'd2;
  localparam logic [2:0] C_JNZ  = 3'd3;
  localparam logic [2:0] C_JC   = 3'd4;
  localparam logic [2:0] C_JNC  = 3'd5;

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pc_q;
  logic                zero_q;
  logic                carry_q;
  logic                br_taken_q;
  logic                cond_err_q;

  logic                zf_eff;
  logic                cf_eff;
  logic                cond_rsvd;
  logic                cond_hit;

  function automatic logic eval_cond(input logic [2:0] cond, input logic zf, input logic cf);
    case (cond)
      C_NONE:  eval_cond = 1'b0;
      C_JMP:   eval_cond = 1'b1;
      C_JZ:    eval_cond = zf;
      C_JNZ:   eval_cond = ~zf;
      C_JC:    eval_cond = cf;
      C_JNC:   eval_cond = ~cf;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  // Flags written this cycle are forwarded so a compare-and-branch pair
  // can resolve in a single step.
  always_comb begin
    zf_eff    = bus.flag_we ? bus.zero_in  : zero_q;
    cf_eff    = bus.flag_we ? bus.carry_in : carry_q;
    cond_rsvd = (bus.br_cond > C_JNC);
    cond_hit  = eval_cond(bus.br_cond, zf_eff, cf_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      pc_q       <= RESET_PC;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      br_taken_q <= 1'b0;
      cond_err_q <= 1'b0;
    end else begin
      br_taken_q <= 1'b0;
      cond_err_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (bus.halt) begin
            state <= ST_HALTED;
          end else begin
            if (bus.flag_we) begin
              zero_q  <= bus.zero_in;
              carry_q <= bus.carry_in;
            end
            if (bus.step) begin
              if (bus.br_valid && cond_rsvd) begin
                pc_q       <= pc_q + PC_WIDTH'(1);
                cond_err_q <= 1'b1;
              end else if (bus.br_valid && cond_hit) begin
                pc_q       <= bus.br_target;
                br_taken_q <= 1'b1;
                state      <= ST_FLUSH;
              end else begin
                pc_q <= pc_q + PC_WIDTH'(1);
              end
            end
          end
        end
        ST_FLUSH:  state <= bus.halt ? ST_HALTED : ST_RUN;
        ST_HALTED: if (!bus.halt) state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.zero_flag  = zero_q;
  assign bus.carry_flag = carry_q;
  assign bus.br_taken   = br_taken_q;
  assign bus.cond_err   = cond_err_q;
  assign bus.flush      = (state == ST_FLUSH);
  assign bus.halted     = (state == ST_HALTED);

endmodule

// File: tb/tb_flags_branch_unit.sv
// Directed bench for flags_branch_unit: a driver queues the expected post-edge
// outputs, a monitor pops and compares them on the following falling edge.
module tb_flags_branch_unit;
  localparam int PC_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_id  = 0;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [5:0]      st;  // {zero_flag, carry_flag, br_taken, flush, cond_err, halted}
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];

  flags_branch_if #(.PC_WIDTH(PC_W)) bus ();

  flags_branch_unit #(.PC_WIDTH(PC_W), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t observe();
    exp_t o;
    o.pc = bus.pc;
    o.st = {bus.zero_flag, bus.carry_flag, bus.br_taken, bus.flush, bus.cond_err, bus.halted};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest queued expectation
  initial begin
    exp_t e;
    exp_t a;
    int   id;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        a  = observe();
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL vec%0d: actual pc=%h zcbfeh=%b required pc=%h zcbfeh=%b",
                   id, a.pc, a.st, e.pc, e.st);
        end
      end
    end
  end

  task automatic cyc(input logic st, input logic fwe, input logic zi, input logic ci,
                     input logic bv, input logic [2:0] cond, input logic [PC_W-1:0] tgt,
                     input logic hl, input logic [PC_W-1:0] epc, input logic [5:0] est);
    exp_t e;
    bus.step      = st;
    bus.flag_we   = fwe;
    bus.zero_in   = zi;
    bus.carry_in  = ci;
    bus.br_valid  = bv;
    bus.br_cond   = cond;
    bus.br_target = tgt;
    bus.halt      = hl;
    @(posedge clk);
    e.pc = epc;
    e.st = est;
    exp_q.push_back(e);
    id_q.push_back(vec_id);
    vec_id++;
    #1;
  endtask

  initial begin
    exp_t r;
    bus.step = 0; bus.flag_we = 0; bus.zero_in = 0; bus.carry_in = 0;
    bus.br_valid = 0; bus.br_cond = 0; bus.br_target = 0; bus.halt = 0;
    repeat (2) @(posedge clk);
    #1;
    r = observe();
    check("reset_pc", 32'(r.pc), 32'h00);
    check("reset_status", 32'(r.st), 32'b000000);
    rst = 1'b0;

    //  st fwe zi ci bv cond  tgt    hl   epc    z c bt fl ce hl
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h01, 6'b000000);
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h02, 6'b000000);
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h03, 6'b000000);
    // forwarded Z, JZ taken
    cyc(1, 1, 1, 0, 1, 3'd2, 8'h40, 0, 8'h40, 6'b101100);
    // flush cycle: step and flag write squashed
    cyc(1, 1, 0, 1, 1, 3'd1, 8'h99, 0, 8'h40, 6'b100000);
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h41, 6'b100000);
    // store Z=0 C=1 without stepping
    cyc(0, 1, 0, 1, 1, 3'd1, 8'h77, 0, 8'h41, 6'b010000);
    // JNZ on stored Z=0 taken
    cyc(1, 0, 0, 0, 1, 3'd3, 8'h10, 0, 8'h10, 6'b011100);
    cyc(0, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h10, 6'b010000);
    // JNC with stored C=1 not taken
    cyc(1, 0, 0, 0, 1, 3'd5, 8'h20, 0, 8'h11, 6'b010000);
    // reserved 6 then 7
    cyc(1, 0, 0, 0, 1, 3'd6, 8'h30, 0, 8'h12, 6'b010010);
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h13, 6'b010000);
    // JC with forwarded C=0 overrides stored C=1: not taken
    cyc(1, 1, 0, 0, 1, 3'd4, 8'h50, 0, 8'h14, 6'b000000);
    cyc(1, 0, 0, 0, 1, 3'd7, 8'h30, 0, 8'h15, 6'b000010);
    // NONE never taken
    cyc(1, 0, 0, 0, 1, 3'd0, 8'h30, 0, 8'h16, 6'b000000);
    // JMP to FF then wrap to 00
    cyc(1, 0, 0, 0, 1, 3'd1, 8'hFF, 0, 8'hFF, 6'b001100);
    cyc(0, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'hFF, 6'b000000);
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, 6'b000000);
    // branch to own pc still flushes; halt during flush goes HALTED
    cyc(1, 0, 0, 0, 1, 3'd1, 8'h00, 0, 8'h00, 6'b001100);
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 1, 8'h00, 6'b000001);
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, 6'b000000);
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h01, 6'b000000);
    // halt beats a JMP with flag write in RUN
    cyc(1, 1, 1, 1, 1, 3'd1, 8'h80, 1, 8'h01, 6'b000001);
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 1, 1, 1, 3'd1, 8'h80, 1, 8'h01, 6'b000001);
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h01, 6'b000000);
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h02, 6'b000000);
    // taken JMP with flags set, then async reset in the flush cycle
    cyc(1, 1, 1, 1, 1, 3'd1, 8'h55, 0, 8'h55, 6'b111100);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    r = observe();
    check("rst_in_flush_pc", 32'(r.pc), 32'h00);
    check("rst_in_flush_status", 32'(r.st), 32'b000000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h01, 6'b000000);
    cyc(0, 0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h01, 6'b000000);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
